// File: rtl/ysyx_22041752_csr_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22041752_csr_pkg
// Shared definitions for the CSR port sequencer: machine CSR addresses,
// request/op codes, mstatus bit positions, trap cause values and the
// sequencer state encoding.
// Optional feature macro used by importers: YSYX_22041752_TIMER_IRQ_EN.
// ----------------------------------------------------------------------------
package ysyx_22041752_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [1:0] {
        REQ_CSR   = 2'b00,
        REQ_ECALL = 2'b01,
        REQ_MRET  = 2'b10,
        REQ_RSVD  = 2'b11
    } req_type_e;

    typedef enum logic [1:0] {
        CSR_WRITE = 2'b00,
        CSR_SET   = 2'b01,
        CSR_CLEAR = 2'b10
    } csr_op_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [63:0] CAUSE_ECALL_M   = 64'hb;
    localparam logic [63:0] CAUSE_TIMER_IRQ = 64'h8000_0000_0000_0007;

    typedef enum logic [3:0] {
        S_IDLE,
        S_OP,
        S_T_TVEC,
        S_T_EPC,
        S_T_CAUSE,
        S_T_STATUS,
        S_R_EPC,
        S_R_STATUS,
        S_NOP
    } state_e;

endpackage

// File: rtl/ysyx_22041752_csr_seq_if.sv
// ----------------------------------------------------------------------------
// ysyx_22041752_csr_seq_if
// Bundles the EXU request/response handshake and the single CSR file port.
//   master : EXU + CSR register file side (drives requests and csr_rdata)
//   slave  : the sequencer (drives req_ready, responses and the CSR port)
// Signals: req_valid/req_ready/req_type/req_csr_op/req_csr_addr/req_wdata/
//          req_pc, resp_valid/resp_rdata/resp_flush/resp_flush_pc,
//          csr_wen/csr_addr/csr_wdata/csr_rdata.
// ----------------------------------------------------------------------------
interface ysyx_22041752_csr_seq_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_type;
    logic [1:0]      req_csr_op;
    logic [11:0]     req_csr_addr;
    logic [XLEN-1:0] req_wdata;
    logic [XLEN-1:0] req_pc;

    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_flush;
    logic [XLEN-1:0] resp_flush_pc;

    logic            csr_wen;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;

    modport master (
        output req_valid, req_type, req_csr_op, req_csr_addr, req_wdata, req_pc,
        output csr_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_flush, resp_flush_pc,
        input  csr_wen, csr_addr, csr_wdata
    );

    modport slave (
        input  req_valid, req_type, req_csr_op, req_csr_addr, req_wdata, req_pc,
        input  csr_rdata,
        output req_ready, resp_valid, resp_rdata, resp_flush, resp_flush_pc,
        output csr_wen, csr_addr, csr_wdata
    );
endinterface

// File: rtl/ysyx_22041752_mstatus_upd.sv
// ----------------------------------------------------------------------------
// ysyx_22041752_mstatus_upd
// Combinational mstatus next value for trap entry and trap return.
//   i_mstatus : current mstatus
//   i_is_mret : 1 = trap return, 0 = trap entry
//   o_mstatus : updated mstatus
// Entry : MPIE <- MIE, MIE <- 0,    MPP <- 2'b11
// Return: MIE <- MPIE, MPIE <- 1,   MPP <- 2'b11 (M-mode only core)
// ----------------------------------------------------------------------------
module ysyx_22041752_mstatus_upd
    import ysyx_22041752_csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_mstatus,
    input  logic            i_is_mret,
    output logic [XLEN-1:0] o_mstatus
);
    always_comb begin
        // NOTE: full default before any conditional write keeps this purely combinational (no latch).
        o_mstatus = i_mstatus;
        o_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        if (i_is_mret) begin
            o_mstatus[MSTATUS_MIE]  = i_mstatus[MSTATUS_MPIE];
            o_mstatus[MSTATUS_MPIE] = 1'b1;
        end else begin
            o_mstatus[MSTATUS_MPIE] = i_mstatus[MSTATUS_MIE];
            o_mstatus[MSTATUS_MIE]  = 1'b0;
        end
    end
endmodule

// File: rtl/ysyx_22041752_csr_seq.sv
// ----------------------------------------------------------------------------
// ysyx_22041752_csr_seq
// Owns the single CSR file port and sequences CSR instruction ops (one
// cycle), ecall trap entry (four cycles) and mret (two cycles). Returns the
// old CSR value or a flush target to the EXU.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   bus (slave) : request/response handshake plus the CSR file port
//   irq_timer, irq_pc : only with YSYX_22041752_TIMER_IRQ_EN; a pending timer
//                 interrupt with mstatus.MIE set enters the trap sequence.
// ----------------------------------------------------------------------------
module ysyx_22041752_csr_seq
    import ysyx_22041752_csr_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(CAUSE_ECALL_M)
) (
    input  logic            clk,
    input  logic            reset,
`ifdef YSYX_22041752_TIMER_IRQ_EN
    input  logic            irq_timer,
    input  logic [XLEN-1:0] irq_pc,
`endif
    ysyx_22041752_csr_seq_if.slave bus
);
    state_e          r_state;
    logic [1:0]      r_op;
    logic [11:0]     r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_target;

    logic            w_irq_take;
    logic            w_accept;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_mstatus_next;

`ifdef YSYX_22041752_TIMER_IRQ_EN
    logic [XLEN-1:0] r_cause;
    // IDLE already drives mstatus onto the port, so MIE is visible here.
    assign w_irq_take = (r_state == S_IDLE) && irq_timer && bus.csr_rdata[MSTATUS_MIE];
    assign w_cause    = r_cause;
`else
    assign w_irq_take = 1'b0;
    assign w_cause    = ECALL_CAUSE;
`endif

    assign bus.req_ready = (r_state == S_IDLE) && !w_irq_take;
    assign w_accept      = bus.req_valid && bus.req_ready;

    ysyx_22041752_mstatus_upd #(.XLEN(XLEN)) u_mstatus_upd (
        .i_mstatus (bus.csr_rdata),
        .i_is_mret (r_state == S_R_STATUS),
        .o_mstatus (w_mstatus_next)
    );

    // NOTE: asynchronous reset in the sensitivity list; all state uses non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_pc     <= '0;
            r_target <= '0;
`ifdef YSYX_22041752_TIMER_IRQ_EN
            r_cause  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
`ifdef YSYX_22041752_TIMER_IRQ_EN
                    if (w_irq_take) begin
                        r_pc    <= irq_pc;
                        r_cause <= XLEN'(CAUSE_TIMER_IRQ);
                        r_state <= S_T_TVEC;
                    end else
`endif
                    if (w_accept) begin
                        // Payload is captured here; later changes on the bus are ignored.
                        r_op    <= bus.req_csr_op;
                        r_addr  <= bus.req_csr_addr;
                        r_wdata <= bus.req_wdata;
                        r_pc    <= bus.req_pc;
`ifdef YSYX_22041752_TIMER_IRQ_EN
                        r_cause <= ECALL_CAUSE;
`endif
                        case (req_type_e'(bus.req_type))
                            REQ_CSR:   r_state <= S_OP;
                            REQ_ECALL: r_state <= S_T_TVEC;
                            REQ_MRET:  r_state <= S_R_EPC;
                            default:   r_state <= S_NOP;
                        endcase
                    end
                end
                S_T_TVEC: begin
                    // Direct mode only: drop the mtvec mode bits.
                    r_target <= {bus.csr_rdata[XLEN-1:2], 2'b00};
                    r_state  <= S_T_EPC;
                end
                S_T_EPC:   r_state <= S_T_CAUSE;
                S_T_CAUSE: r_state <= S_T_STATUS;
                S_R_EPC: begin
                    r_target <= bus.csr_rdata;
                    r_state  <= S_R_STATUS;
                end
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // CSR port and response are decoded from the state and latched payload;
    // read-modify-write data must follow csr_rdata within the same cycle.
    always_comb begin
        bus.csr_addr      = CSR_MSTATUS;
        bus.csr_wen       = 1'b0;
        bus.csr_wdata     = '0;
        bus.resp_valid    = 1'b0;
        bus.resp_rdata    = '0;
        bus.resp_flush    = 1'b0;
        bus.resp_flush_pc = '0;
        case (r_state)
            S_OP: begin
                bus.csr_addr   = r_addr;
                bus.resp_valid = 1'b1;
                bus.resp_rdata = bus.csr_rdata;
                case (csr_op_e'(r_op))
                    CSR_WRITE: begin
                        bus.csr_wdata = r_wdata;
                        bus.csr_wen   = 1'b1;
                    end
                    CSR_SET: begin
                        bus.csr_wdata = bus.csr_rdata | r_wdata;
                        bus.csr_wen   = |r_wdata;
                    end
                    CSR_CLEAR: begin
                        bus.csr_wdata = bus.csr_rdata & ~r_wdata;
                        bus.csr_wen   = |r_wdata;
                    end
                    default: bus.csr_wdata = bus.csr_rdata;
                endcase
            end
            S_T_TVEC: bus.csr_addr = CSR_MTVEC;
            S_T_EPC: begin
                bus.csr_addr  = CSR_MEPC;
                bus.csr_wen   = 1'b1;
                bus.csr_wdata = r_pc;
            end
            S_T_CAUSE: begin
                bus.csr_addr  = CSR_MCAUSE;
                bus.csr_wen   = 1'b1;
                bus.csr_wdata = w_cause;
            end
            S_R_EPC: bus.csr_addr = CSR_MEPC;
            S_T_STATUS, S_R_STATUS: begin
                bus.csr_addr      = CSR_MSTATUS;
                bus.csr_wen       = 1'b1;
                bus.csr_wdata     = w_mstatus_next;
                bus.resp_valid    = 1'b1;
                bus.resp_flush    = 1'b1;
                bus.resp_flush_pc = r_target;
            end
            S_NOP: bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/ysyx_22041752_csr_seq.md
Name: ysyx_22041752_csr_seq

Overview:
- Sequencer for the single-port CSR file; the CSR port is one address, one combinational read and one synchronous write per cycle.
- Arbitrates the port between instruction CSR ops (csrrw/csrrs/csrrc) and the multi-step trap-entry (ecall) and trap-return (mret) sequences.
- Sits between the EXU and the CSR register file and returns old CSR values plus flush target PCs to the EXU.
- Replaces ad-hoc CSR sequencing inside the execute stage.

Parameters:
- XLEN, 64, CSR/PC data width
- ECALL_CAUSE, 64'hb, mcause value written on ecall from M-mode

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  1  request present; held until accepted
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_type  in  2  00 CSR op, 01 ecall, 10 mret, 11 reserved
- req_csr_op  in  2  00 write, 01 set, 10 clear
- req_csr_addr  in  12  target CSR for a CSR op
- req_wdata  in  XLEN  rs1 value
- req_pc  in  XLEN  PC of the requesting instruction
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_rdata  out  XLEN  old CSR value (CSR op), else 0
- resp_flush  out  1  valid with resp_valid; redirect the pipeline
- resp_flush_pc  out  XLEN  redirect target
- csr_wen  out  1  CSR write enable
- csr_addr  out  12  CSR address
- csr_wdata  out  XLEN  CSR write data
- csr_rdata  in  XLEN  combinational read of csr_addr

Behaviour:
- Reset: asynchronous; state=IDLE, payload registers and target register =0; all outputs =0 except req_ready=1 and csr_addr=12'h300.
- Handshake: req_ready=1 only in IDLE. The request is latched on accept. Throughput is at most 1 request per 2 cycles.
- IDLE: csr_addr=mstatus (0x300) and csr_wen=0. On accept, go to OP / T_TVEC / R_EPC / NOP according to req_type.
- OP (accept T, active T+1):
  - csr_addr = latched address.
  - csr_wdata: write → wdata; set → rdata|wdata; clear → rdata&~wdata.
  - csr_wen=1, except set/clear with wdata==0, which gives csr_wen=0.
  - resp_valid=1, resp_rdata = csr_rdata (old value), resp_flush=0.
  - Next state IDLE.
- Ecall sequence (response at T+4):
  - T_TVEC: addr 0x305; the target register captures {rdata[63:2],2'b00}.
  - T_EPC: write mepc = latched pc.
  - T_CAUSE: write mcause = ECALL_CAUSE.
  - T_STATUS: write mstatus with MPIE←MIE, MIE←0, MPP←2'b11. resp_valid=1, resp_flush=1, resp_flush_pc = target. Next state IDLE.
- Mret sequence (response at T+2):
  - R_EPC: addr 0x341; the target register captures rdata.
  - R_STATUS: write mstatus with MIE←MPIE, MPIE←1, MPP←2'b11. resp_valid=1, resp_flush=1, resp_flush_pc = target. Next state IDLE.
- NOP (reserved type): resp_valid=1 at T+1 with rdata=0, flush=0, no write.
- Boundaries:
  - req_valid while busy is ignored; the requester holds its request.
  - Payload changes while busy are ignored because the payload is latched at accept.
  - Reset mid-sequence aborts to IDLE; CSR writes already performed are not undone.
  - In any cycle, csr_wen=1 only in OP, T_EPC, T_CAUSE, T_STATUS and R_STATUS.
  - A CSR op targeting mstatus/mepc is a plain RMW with no special ordering.

Optional Feature:
- Macro: YSYX_22041752_TIMER_IRQ_EN.
- With the macro:
  - Adds inputs irq_timer (1) and irq_pc (XLEN).
  - In IDLE, if irq_timer && csr_rdata[3] (mstatus.MIE), the interrupt takes priority over req_valid: req_ready=0 that cycle and the block enters T_TVEC.
  - mepc = irq_pc; mcause = 64'h8000_0000_0000_0007.
  - The rest of the trap sequence and the flush response are identical to ecall.
- Without the macro: the ports are absent and only ecall causes trap entry.

Decomposition:
- Package ysyx_22041752_csr_pkg holds:
  - CSR addresses MSTATUS/MTVEC/MEPC/MCAUSE;
  - req_type and csr_op codes;
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11);
  - cause constants;
  - the state enum.
- Sub-module ysyx_22041752_mstatus_upd: combinational trap/return mstatus next-value function, reused later by interrupt logic.

Test Plan:
- Reset held with req_valid=1 → req_ready=1, resp_valid=0, csr_wen=0; after release, the request is accepted next edge.
- csrrs on 0x300 with mstatus=0x8, wdata=0x80 → at T+1 csr_wen=1, csr_wdata=0x88, resp_rdata=0x8; csrrc with wdata=0 → csr_wen=0.
- ecall, pc=0x8000_0010, mtvec=0x8000_0101, mstatus=0x8 → mepc=0x8000_0010, mcause=0xb, mstatus=0x1880, and resp_flush_pc=0x8000_0100 at T+4.
- mret with mepc=0x8000_0014, mstatus=0x1880 → mstatus=0x1888, and resp_flush_pc=0x8000_0014 at T+2.
- Back-to-back requests, with a second request held during the ecall → req_ready stays 0 for 4 cycles; the second request is accepted at T+5.
- Reset asserted in T_CAUSE → state returns to IDLE immediately, mepc keeps its new value, mcause is unchanged, and there is no resp_valid.
